// File: rtl/init_pkg.sv
// Shared definitions for the bring-up sequencer: FSM state encoding,
// counter/delay field width, fault index width and index sizing helper.
package init_pkg;

    localparam int unsigned DELAY_W       = 32;
    localparam int unsigned FAULT_STAGE_W = 8;
    localparam int unsigned RETRY_W       = 8;

    typedef enum logic [2:0] {
        WAIT,
        START,
        BUSY,
        READY,
        FAULT
    } state_t;

    // Stage index width: clog2(stages), never below one bit.
    function automatic int unsigned idx_width(input int unsigned stages);
        return (stages > 1) ? $clog2(stages) : 1;
    endfunction

endpackage

// File: rtl/init_sequencer_if.sv
// Handshake bundle between the sequencer and the blocks it brings up.
//   done        : per-stage completion from downstream
//   restart     : one-cycle request to rerun after a fault
//   start       : one-hot one-cycle start pulse
//   enabled     : sticky per-stage completion flags
//   ready/fault : terminal status, fault_stage = failing stage index
interface init_sequencer_if
    import init_pkg::*;
#(
    parameter int unsigned STAGES = 4
);

    logic [STAGES-1:0]        done;
    logic                     restart;
    logic [STAGES-1:0]        start;
    logic [STAGES-1:0]        enabled;
    logic                     ready;
    logic                     fault;
    logic [FAULT_STAGE_W-1:0] fault_stage;

    modport master (
        input  done,
        input  restart,
        output start,
        output enabled,
        output ready,
        output fault,
        output fault_stage
    );

    modport slave (
        output done,
        output restart,
        input  start,
        input  enabled,
        input  ready,
        input  fault,
        input  fault_stage
    );

endinterface

// File: rtl/seq_counter.sv
// Free-running cycle counter with synchronous clear and an equality match
// against a target.
//   clock, reset : system clock, synchronous active-high reset
//   clear        : force count to zero this edge (wins over inc)
//   inc          : advance count by one
//   target       : compare value
//   match_c      : count == target (combinational decode of the register)
module seq_counter
    import init_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               inc,
    input  logic [DELAY_W-1:0] target,
    output logic               match_c
);

    logic [DELAY_W-1:0] count;

    // Count register; wrap is unreachable because the owner clears on match.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + DELAY_W'(1);
        end
    end

    assign match_c = (count == target);

endmodule

// File: rtl/init_sequencer.sv
// Power-up sequencer: walks STAGES stages in order, each one being a
// programmed delay, a one-cycle start pulse and a done wait bounded by a
// timeout with a limited number of retries. Ends in READY or a latched FAULT.
//   clock, reset : system clock, synchronous active-high reset
//   bus          : master side of init_sequencer_if (done/restart in,
//                  start/enabled/ready/fault/fault_stage out)
module init_sequencer
    import init_pkg::*;
#(
    parameter int unsigned                  STAGES  = 4,
    parameter logic [DELAY_W*STAGES-1:0]    DELAYS  = {STAGES{32'd1}},
    parameter logic [DELAY_W-1:0]           TIMEOUT = 32'd1000000,
    parameter int unsigned                  RETRIES = 2
) (
    input  logic             clock,
    input  logic             reset,
    init_sequencer_if.master bus
);

    localparam int unsigned        IDX_W    = idx_width(STAGES);
    localparam logic [DELAY_W-1:0] TMO_LAST = TIMEOUT - DELAY_W'(1);

    state_t                   state;
    logic [IDX_W-1:0]         idx;
    logic [RETRY_W-1:0]       retry;
    logic [STAGES-1:0]        start_q;
    logic [STAGES-1:0]        enabled_q;
    logic                     ready_q;
    logic                     fault_q;
    logic [FAULT_STAGE_W-1:0] fault_stage_q;

    logic [STAGES-1:0]        stage_mask;
    logic [DELAY_W-1:0]       delay_sel;
    logic                     done_sel;
    logic                     last_stage;
    logic                     wait_run;
    logic                     busy_run;
    logic                     wait_hit;
    logic                     tmo_hit;

    // Decode the current stage: one-hot mask, its delay field, its done bit.
    always_comb begin
        stage_mask = '0;
        delay_sel  = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            if (IDX_W'(i) == idx) begin
                stage_mask[i] = 1'b1;
                delay_sel     = DELAYS[i*DELAY_W +: DELAY_W];
            end
        end
    end

    assign done_sel   = |(bus.done & stage_mask);
    assign last_stage = (idx == IDX_W'(STAGES - 1));

    // Each counter runs only in its own state and sits at zero otherwise,
    // so it always starts from 0 on the first cycle of that state.
    assign wait_run = (state == WAIT);
    assign busy_run = (state == BUSY);

    seq_counter u_wait (
        .clock   (clock),
        .reset   (reset),
        .clear   (!wait_run),
        .inc     (wait_run),
        .target  (delay_sel),
        .match_c (wait_hit)
    );

    seq_counter u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (!busy_run),
        .inc     (busy_run),
        .target  (TMO_LAST),
        .match_c (tmo_hit)
    );

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= WAIT;
            idx           <= '0;
            retry         <= '0;
            start_q       <= '0;
            enabled_q     <= '0;
            ready_q       <= 1'b0;
            fault_q       <= 1'b0;
            fault_stage_q <= '0;
        end else begin
            start_q <= '0;
            case (state)
                WAIT: begin
                    if (wait_hit) begin
                        state   <= START;
                        start_q <= stage_mask;
                    end
                end
                START: begin
                    state <= BUSY;
                end
                BUSY: begin
                    // done takes priority over a coincident timeout
                    if (done_sel) begin
                        enabled_q <= enabled_q | stage_mask;
                        retry     <= '0;
                        if (last_stage) begin
                            state   <= READY;
                            ready_q <= 1'b1;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= WAIT;
                        end
                    end else if (tmo_hit) begin
                        if (retry < RETRY_W'(RETRIES)) begin
                            retry <= retry + RETRY_W'(1);
                            state <= WAIT;
                        end else begin
                            state         <= FAULT;
                            fault_q       <= 1'b1;
                            fault_stage_q <= FAULT_STAGE_W'(idx);
                        end
                    end
                end
                READY: begin
                    state <= READY;
                end
                FAULT: begin
                    if (bus.restart) begin
                        enabled_q <= '0;
                        fault_q   <= 1'b0;
                        retry     <= '0;
                        idx       <= '0;
                        state     <= WAIT;
                    end
                end
                default: begin
                    state <= WAIT;
                end
            endcase
        end
    end

    assign bus.start       = start_q;
    assign bus.enabled     = enabled_q;
    assign bus.ready       = ready_q;
    assign bus.fault       = fault_q;
    assign bus.fault_stage = fault_stage_q;

endmodule

// File: tb/tb_init_sequencer.sv
// Directed bench for init_sequencer. Instance a: 3 stages, delays {5,0,2},
// timeout 10, 2 retries. Instance b: 2 stages, zero delays, timeout 4,
// 1 retry, for the timeout/done boundary cases.
module tb_init_sequencer;

    logic clock = 1'b0;
    logic reset_a;
    logic reset_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    init_sequencer_if #(.STAGES(3)) ifa ();
    init_sequencer_if #(.STAGES(2)) ifb ();

    init_sequencer #(
        .STAGES  (3),
        .DELAYS  ({32'd5, 32'd0, 32'd2}),
        .TIMEOUT (32'd10),
        .RETRIES (2)
    ) u_a (
        .clock (clock),
        .reset (reset_a),
        .bus   (ifa)
    );

    init_sequencer #(
        .STAGES  (2),
        .DELAYS  ({32'd0, 32'd0}),
        .TIMEOUT (32'd4),
        .RETRIES (1)
    ) u_b (
        .clock (clock),
        .reset (reset_b),
        .bus   (ifb)
    );

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Answer the current stage of instance a three cycles after its start.
    task automatic ans_a(input logic [2:0] b);
        tick(3);
        ifa.done = b;
        tick();
        ifa.done = 3'b000;
    endtask

    // Bounded wait for the next start pulse on instance a.
    task automatic wait_start_a(input string tag, input logic [2:0] exp, input int budget);
        for (int k = 0; k < budget; k++) begin
            tick();
            if (ifa.start != 3'b000) break;
        end
        check(tag, 32'(ifa.start), 32'(exp));
    endtask

    initial begin
        reset_a     = 1'b1;
        reset_b     = 1'b1;
        ifa.done    = '0;
        ifa.restart = 1'b0;
        ifb.done    = '0;
        ifb.restart = 1'b0;
        tick(2);

        check("rst_start",   32'(ifa.start),       32'h0);
        check("rst_enabled", 32'(ifa.enabled),     32'h0);
        check("rst_ready",   32'(ifa.ready),       32'h0);
        check("rst_fault",   32'(ifa.fault),       32'h0);
        check("rst_fstage",  32'(ifa.fault_stage), 32'h0);

        // Full run, with done[2] held high during stage 0.
        reset_a = 1'b0;
        tick(2);
        check("s0_wait", 32'(ifa.start), 32'h0);
        tick();
        check("s0_start", 32'(ifa.start), 32'h1);
        ifa.done = 3'b100;
        tick(3);
        check("s0_done2_ignored", 32'(ifa.enabled), 32'h0);
        ifa.done = 3'b101;
        tick();
        ifa.done = 3'b000;
        check("s0_enabled", 32'(ifa.enabled), 32'h1);
        tick();
        check("s1_start", 32'(ifa.start), 32'h2);
        ans_a(3'b010);
        check("s1_enabled", 32'(ifa.enabled), 32'h3);
        tick(5);
        check("s2_wait", 32'(ifa.start), 32'h0);
        tick();
        check("s2_start", 32'(ifa.start), 32'h4);
        tick(3);
        check("s2_not_ready", 32'(ifa.ready), 32'h0);
        ifa.done = 3'b100;
        tick();
        ifa.done = 3'b000;
        check("run_enabled", 32'(ifa.enabled), 32'h7);
        check("run_ready",   32'(ifa.ready),   32'h1);
        check("run_fault",   32'(ifa.fault),   32'h0);
        ifa.restart = 1'b1;
        tick();
        ifa.restart = 1'b0;
        check("ready_hold",   32'(ifa.ready),   32'h1);
        check("ready_enable", 32'(ifa.enabled), 32'h7);
        tick();
        check("ready_nostart", 32'(ifa.start), 32'h0);

        // Reset while stage 2 is busy.
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        tick(3);
        check("r2_s0_start", 32'(ifa.start), 32'h1);
        ans_a(3'b001);
        tick();
        check("r2_s1_start", 32'(ifa.start), 32'h2);
        ans_a(3'b010);
        tick(6);
        check("r2_s2_start", 32'(ifa.start), 32'h4);
        tick(2);
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        check("mid_start",   32'(ifa.start),       32'h0);
        check("mid_enabled", 32'(ifa.enabled),     32'h0);
        check("mid_ready",   32'(ifa.ready),       32'h0);
        check("mid_fault",   32'(ifa.fault),       32'h0);
        check("mid_fstage",  32'(ifa.fault_stage), 32'h0);
        tick(2);
        check("mid_wait", 32'(ifa.start), 32'h0);
        tick();
        check("mid_s0_start", 32'(ifa.start), 32'h1);

        // Stage 1 never answers: three pulses 12 cycles apart, then fault.
        ans_a(3'b001);
        check("to_enabled", 32'(ifa.enabled), 32'h1);
        tick();
        check("to_pulse1", 32'(ifa.start), 32'h2);
        for (int p = 2; p <= 3; p++) begin
            tick(11);
            check("to_gap", 32'(ifa.start), 32'h0);
            tick();
            check("to_pulse", 32'(ifa.start), 32'h2);
        end
        tick(10);
        check("to_not_yet", 32'(ifa.fault), 32'h0);
        tick();
        check("to_fault",   32'(ifa.fault),       32'h1);
        check("to_fstage",  32'(ifa.fault_stage), 32'h1);
        check("to_enabled", 32'(ifa.enabled),     32'h1);
        check("to_ready",   32'(ifa.ready),       32'h0);
        tick(3);
        check("to_hold",    32'(ifa.fault),       32'h1);
        check("to_nostart", 32'(ifa.start),       32'h0);

        // Restart from fault and complete.
        ifa.restart = 1'b1;
        tick();
        ifa.restart = 1'b0;
        check("rs_enabled", 32'(ifa.enabled), 32'h0);
        check("rs_fault",   32'(ifa.fault),   32'h0);
        tick(2);
        check("rs_wait", 32'(ifa.start), 32'h0);
        tick();
        check("rs_s0_start", 32'(ifa.start), 32'h1);
        ans_a(3'b001);
        wait_start_a("rs_s1_start", 3'b010, 20);
        ans_a(3'b010);
        wait_start_a("rs_s2_start", 3'b100, 20);
        ans_a(3'b100);
        check("rs_ready",   32'(ifa.ready),   32'h1);
        check("rs_fault2",  32'(ifa.fault),   32'h0);
        check("rs_enabled2", 32'(ifa.enabled), 32'h7);

        // Instance b: done only in START is ignored; done in last BUSY cycle wins.
        reset_b = 1'b0;
        tick();
        check("b_s0_start", 32'(ifb.start), 32'h1);
        ifb.done = 2'b01;
        tick();
        ifb.done = 2'b00;
        tick(4);
        check("b_start_done_ignored", 32'(ifb.enabled), 32'h0);
        check("b_no_fault",           32'(ifb.fault),   32'h0);
        tick();
        check("b_retry_start", 32'(ifb.start), 32'h1);
        tick(4);
        ifb.done = 2'b01;
        tick();
        ifb.done = 2'b00;
        check("b_last_cycle_done", 32'(ifb.enabled), 32'h1);
        check("b_last_no_fault",   32'(ifb.fault),   32'h0);
        tick();
        check("b_s1_start", 32'(ifb.start), 32'h2);
        tick();
        ifb.done = 2'b10;
        tick();
        ifb.done = 2'b00;
        check("b_enabled", 32'(ifb.enabled), 32'h3);
        check("b_ready",   32'(ifb.ready),   32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
